// File: rtl/uart_pkg.sv
// Shared types and default sizing for the UART word packer.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package uart_pkg;

    // Default packing width and buffer depth
    localparam int DEF_BYTES_PER_WORD = 2;
    localparam int DEF_DEPTH          = 4096;
    localparam int DEF_TIMEOUT_CYC    = 52080;

    // Capture control states
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/uart_dpram.sv
// Simple dual-port RAM: one write port, one registered read port, no reset on contents.
// Latency: rd_dat valid one cycle after rd_en; a word written at edge N is readable by a read issued at edge N+1.
// Backpressure: none; the owner only enables reads and writes when they are legal.
module uart_dpram #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4096
) (
    input  logic                     CLOCK_50,
    input  logic                     wr_en,
    input  logic [$clog2(DEPTH)-1:0] wr_addr,
    input  logic [WIDTH-1:0]         wr_dat,
    input  logic                     rd_en,
    input  logic [$clog2(DEPTH)-1:0] rd_addr,
    output logic [WIDTH-1:0]         rd_dat
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Write port
    always_ff @(posedge CLOCK_50) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_dat;
        end
    end

    // Registered read port; output holds its last word while rd_en is low
    always_ff @(posedge CLOCK_50) begin
        if (rd_en) begin
            rd_dat <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/uart_word_packer.sv
// Packs UART receive bytes little-endian into words and buffers them in a show-ahead FIFO; optional partial-word timeout flush under UART_PACK_TIMEOUT_EN.
// Latency: RD_VALID rises 2 cycles after a word is written into an empty buffer; back-to-back pops stream with no bubble.
// Backpressure: RD_READY stalls the output (RD_DATA held); a completed word arriving at a full buffer is dropped and OVERFLOW is set.
module uart_word_packer
    import uart_pkg::*;
#(
    parameter int BYTES_PER_WORD = DEF_BYTES_PER_WORD,
    parameter int DEPTH          = DEF_DEPTH,
    parameter int TIMEOUT_CYC    = DEF_TIMEOUT_CYC
) (
    input  logic                          CLOCK_50,
    input  logic                          RST_N,
    input  logic [7:0]                    RX_DATA,
    input  logic                          RX_BUSY,
    input  logic                          START_N,
    input  logic                          STOP_N,
    input  logic                          RD_READY,
    output logic                          RD_VALID,
    output logic [8*BYTES_PER_WORD-1:0]   RD_DATA,
    output logic [$clog2(DEPTH):0]        COUNT,
    output logic                          OVERFLOW,
    output logic                          CAPTURING
);

    localparam int W      = 8 * BYTES_PER_WORD;
    localparam int PTR_W  = $clog2(DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int LANE_W = (BYTES_PER_WORD > 1) ? $clog2(BYTES_PER_WORD) : 1;

    localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(BYTES_PER_WORD - 1);
    localparam logic [CNT_W-1:0]  FULL_CNT  = CNT_W'(DEPTH);

    state_t            state;
    logic              busy_q;
    logic [LANE_W-1:0] lane;
    logic [W-1:0]      partial;
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  ram_cnt;     // words in RAM not yet fetched into the read pipeline
    logic              s1_vld;      // RAM read register holds a fetched word
    logic [W-1:0]      ram_rd_dat;

    logic              byte_stb;
    logic              stop_req;
    logic              start_req;
    logic              run;
    logic              cap_stb;
    logic              tmo_fire;
    logic              wr_req;
    logic              accept;
    logic              drop;
    logic              pop;
    logic              s1_move;
    logic              issue;
    logic [W-1:0]      word_ins;
    logic [W-1:0]      wr_dat;

    // Byte completes on the falling edge of the receiver busy flag
    assign byte_stb  = busy_q & ~RX_BUSY;
    // STOP has priority over START when both are asserted
    assign stop_req  = ~STOP_N;
    assign start_req = ~START_N & STOP_N;
    assign run       = (state == ST_RUN);
    assign cap_stb   = run & byte_stb & ~stop_req;

    // Current partial word with the incoming byte dropped into its lane
    always_comb begin
        word_ins = partial;
        word_ins[{lane, 3'b000} +: 8] = RX_DATA;
    end

`ifdef UART_PACK_TIMEOUT_EN
    localparam int TMR_W = $clog2(TIMEOUT_CYC + 1);

    logic [TMR_W-1:0] idle_tmr;

    // Flush fires on the TIMEOUT_CYC-th strobe-free cycle after the last byte
    assign tmo_fire = run & ~stop_req & ~byte_stb & (lane != '0) &
                      (idle_tmr == TMR_W'(TIMEOUT_CYC - 1));

    // Idle timer counts only while a partial word is pending in RUN
    always_ff @(posedge CLOCK_50) begin
        if (!RST_N || !run || stop_req || byte_stb || (lane == '0) || tmo_fire) begin
            idle_tmr <= '0;
        end else begin
            idle_tmr <= idle_tmr + TMR_W'(1);
        end
    end
`else
    // Partial words wait indefinitely; TIMEOUT_CYC is inert in this build
    assign tmo_fire = (TIMEOUT_CYC < 0);
`endif

    // Word write request: lane wrap on a captured byte, or a timeout flush
    assign wr_req  = (cap_stb & (lane == LAST_LANE)) | tmo_fire;
    assign wr_dat  = tmo_fire ? partial : word_ins;

    // A pop in the same cycle frees a slot for a write to a full buffer
    assign pop     = RD_VALID & RD_READY;
    assign accept  = wr_req & ((COUNT != FULL_CNT) | pop);
    assign drop    = wr_req & ~accept;

    // Read pipeline: RAM read register feeds the output register
    assign s1_move = s1_vld & (~RD_VALID | pop);
    assign issue   = (ram_cnt != '0) & (~s1_vld | s1_move);

    uart_dpram #(
        .WIDTH (W),
        .DEPTH (DEPTH)
    ) u_ram (
        .CLOCK_50 (CLOCK_50),
        .wr_en    (accept),
        .wr_addr  (wr_ptr),
        .wr_dat   (wr_dat),
        .rd_en    (issue),
        .rd_addr  (rd_ptr),
        .rd_dat   (ram_rd_dat)
    );

    // Capture state machine, sticky overflow and busy-edge register
    always_ff @(posedge CLOCK_50) begin
        if (!RST_N) begin
            state     <= ST_IDLE;
            CAPTURING <= 1'b0;
            OVERFLOW  <= 1'b0;
            busy_q    <= 1'b1;
        end else begin
            busy_q <= RX_BUSY;
            if (stop_req) begin
                state     <= ST_IDLE;
                CAPTURING <= 1'b0;
            end else if (start_req && !run) begin
                state     <= ST_RUN;
                CAPTURING <= 1'b1;
                OVERFLOW  <= 1'b0;
            end else if (drop) begin
                OVERFLOW  <= 1'b1;
            end
        end
    end

    // Lane packing, buffer pointers, occupancy and show-ahead output stage
    always_ff @(posedge CLOCK_50) begin
        if (!RST_N || stop_req) begin
            lane     <= '0;
            partial  <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            ram_cnt  <= '0;
            COUNT    <= '0;
            s1_vld   <= 1'b0;
            RD_VALID <= 1'b0;
            RD_DATA  <= '0;
        end else begin
            if (cap_stb) begin
                if (lane == LAST_LANE) begin
                    lane    <= '0;
                    partial <= '0;
                end else begin
                    lane    <= lane + LANE_W'(1);
                    partial <= word_ins;
                end
            end else if (tmo_fire) begin
                lane    <= '0;
                partial <= '0;
            end

            if (accept) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (issue) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end

            ram_cnt <= ram_cnt + CNT_W'(accept) - CNT_W'(issue);
            COUNT   <= COUNT + CNT_W'(accept) - CNT_W'(pop);

            if (issue) begin
                s1_vld <= 1'b1;
            end else if (s1_move) begin
                s1_vld <= 1'b0;
            end

            if (s1_move) begin
                RD_VALID <= 1'b1;
                RD_DATA  <= ram_rd_dat;
            end else if (pop) begin
                RD_VALID <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_word_packer.sv
// Randomised and directed bench for uart_word_packer with a queue-based reference model.
// Latency: checks the 2-cycle show-ahead latency and the timeout flush point.
// Backpressure: drives RD_READY directed and random; a negedge monitor scores every pop.
module tb_uart_word_packer;

    localparam int BPW   = 2;
    localparam int DEPTH = 4;
    localparam int TMO   = 100;
    localparam int W     = 8 * BPW;

    logic                   CLOCK_50 = 1'b0;
    logic                   RST_N;
    logic [7:0]             RX_DATA;
    logic                   RX_BUSY;
    logic                   START_N;
    logic                   STOP_N;
    logic                   RD_READY;
    logic                   RD_VALID;
    logic [W-1:0]           RD_DATA;
    logic [$clog2(DEPTH):0] COUNT;
    logic                   OVERFLOW;
    logic                   CAPTURING;

    int          n_checks = 0;
    int          n_err    = 0;
    logic [W-1:0] exp_q[$];
    logic [7:0]   m_part[$];
    bit           m_run    = 1'b0;
    bit           m_ovf    = 1'b0;
    bit           rand_rdy = 1'b0;
    bit           prev_hold = 1'b0;
    logic [W-1:0] prev_dat = '0;

    uart_word_packer #(
        .BYTES_PER_WORD (BPW),
        .DEPTH          (DEPTH),
        .TIMEOUT_CYC    (TMO)
    ) dut (
        .CLOCK_50  (CLOCK_50),
        .RST_N     (RST_N),
        .RX_DATA   (RX_DATA),
        .RX_BUSY   (RX_BUSY),
        .START_N   (START_N),
        .STOP_N    (STOP_N),
        .RD_READY  (RD_READY),
        .RD_VALID  (RD_VALID),
        .RD_DATA   (RD_DATA),
        .COUNT     (COUNT),
        .OVERFLOW  (OVERFLOW),
        .CAPTURING (CAPTURING)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: bytes collect into a word; a word joins the buffer if room remains
    task automatic model_byte(input logic [7:0] d);
        logic [W-1:0] w;
        if (!m_run) return;
        m_part.push_back(d);
        if (m_part.size() == BPW) begin
            w = '0;
            for (int i = 0; i < BPW; i++) w = w | (W'(m_part[i]) << (8 * i));
            m_part.delete();
            if (exp_q.size() < DEPTH) exp_q.push_back(w);
            else m_ovf = 1'b1;
        end
    endtask

    task automatic model_clear();
        m_run = 1'b0;
        exp_q.delete();
        m_part.delete();
    endtask

    // Monitor: scores every word the consumer accepts, and output hold under stall
    always @(negedge CLOCK_50) begin
        if (RST_N) begin
            if (prev_hold && RD_VALID) check("rd_data_hold", 32'(RD_DATA), 32'(prev_dat));
            if (RD_VALID && RD_READY) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_err++;
                    $display("FAIL unexpected_word: got 0x%0h with nothing expected at %0t", RD_DATA, $time);
                end else begin
                    check("rd_data", 32'(RD_DATA), 32'(exp_q.pop_front()));
                end
            end
        end
        prev_hold = RST_N && RD_VALID && !RD_READY;
        prev_dat  = RD_DATA;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge CLOCK_50);
        #1;
        if (rand_rdy) RD_READY = ($urandom_range(0, 3) != 0);
    endtask

    task automatic send_byte(input logic [7:0] d, input bit pop_pulse);
        RX_DATA = d;
        RX_BUSY = 1'b1;
        tick();
        RX_BUSY = 1'b0;
        if (pop_pulse) RD_READY = 1'b1;
        @(negedge CLOCK_50);
        #1;
        model_byte(d);
        tick();
        if (pop_pulse) RD_READY = 1'b0;
    endtask

    task automatic start_pulse();
        START_N = 1'b0;
        @(negedge CLOCK_50);
        #1;
        if (!m_run) begin
            m_run = 1'b1;
            m_ovf = 1'b0;
        end
        tick();
        START_N = 1'b1;
    endtask

    task automatic stop_pulse();
        STOP_N = 1'b0;
        @(negedge CLOCK_50);
        #1;
        model_clear();
        tick();
        STOP_N = 1'b1;
    endtask

    task automatic reset_pulse();
        RST_N = 1'b0;
        @(negedge CLOCK_50);
        #1;
        model_clear();
        m_ovf = 1'b0;
        tick();
        tick();
        RST_N = 1'b1;
    endtask

    task automatic drain(input int n, input string name);
        RD_READY = 1'b1;
        repeat (n) tick();
        RD_READY = 1'b0;
        check({name, "_model_empty"}, exp_q.size(), 0);
        check({name, "_count_zero"}, 32'(COUNT), 0);
    endtask

    initial begin
        int k;
        RST_N    = 1'b0;
        RX_DATA  = 8'h00;
        RX_BUSY  = 1'b0;
        START_N  = 1'b1;
        STOP_N   = 1'b1;
        RD_READY = 1'b0;
        repeat (3) tick();
        RST_N = 1'b1;
        tick();

        // Reset state
        check("rst_rd_valid", 32'(RD_VALID), 0);
        check("rst_rd_data", 32'(RD_DATA), 0);
        check("rst_count", 32'(COUNT), 0);
        check("rst_overflow", 32'(OVERFLOW), 0);
        check("rst_capturing", 32'(CAPTURING), 0);

        // Single word, little-endian, 2-cycle latency
        start_pulse();
        check("start_capturing", 32'(CAPTURING), 1);
        send_byte(8'h34, 1'b0);
        send_byte(8'h12, 1'b0);
        check("lat_cycle0_valid", 32'(RD_VALID), 0);
        tick();
        check("lat_cycle1_valid", 32'(RD_VALID), 0);
        tick();
        check("lat_cycle2_valid", 32'(RD_VALID), 1);
        check("first_word", 32'(RD_DATA), 32'h1234);
        drain(4, "first");

        // Fill a 4-deep buffer with no reader: fifth word dropped
        for (int i = 0; i < 10; i++) send_byte(8'($urandom_range(0, 255)), 1'b0);
        check("full_count", 32'(COUNT), DEPTH);
        check("full_overflow", 32'(OVERFLOW), 1);
        check("full_overflow_model", 32'(OVERFLOW), 32'(m_ovf));
        drain(10, "overflow_drain");

        // Pop in the same cycle as a write to a full buffer
        stop_pulse();
        start_pulse();
        check("restart_overflow_clear", 32'(OVERFLOW), 0);
        for (int i = 0; i < 8; i++) send_byte(8'h10 + 8'(i), 1'b0);
        repeat (3) tick();
        check("pre_pop_count", 32'(COUNT), DEPTH);
        check("pre_pop_valid", 32'(RD_VALID), 1);
        send_byte(8'hC1, 1'b0);
        send_byte(8'hC2, 1'b1);
        check("pop_write_count", 32'(COUNT), DEPTH);
        check("pop_write_overflow", 32'(OVERFLOW), 0);
        drain(10, "pop_write");

        // Stop after 1.5 words clears everything, no stale lane after restart
        send_byte(8'h01, 1'b0);
        send_byte(8'h02, 1'b0);
        send_byte(8'h03, 1'b0);
        stop_pulse();
        check("stop_count", 32'(COUNT), 0);
        check("stop_rd_valid", 32'(RD_VALID), 0);
        check("stop_capturing", 32'(CAPTURING), 0);
        start_pulse();
        send_byte(8'hAA, 1'b0);
        send_byte(8'hBB, 1'b0);
        repeat (2) tick();
        check("restart_word", 32'(RD_DATA), 32'hBBAA);
        drain(4, "restart");

        // START and STOP together: STOP wins, bytes ignored
        START_N = 1'b0;
        STOP_N  = 1'b0;
        @(negedge CLOCK_50);
        #1;
        model_clear();
        tick();
        START_N = 1'b1;
        STOP_N  = 1'b1;
        check("both_low_capturing", 32'(CAPTURING), 0);
        send_byte(8'h5A, 1'b0);
        send_byte(8'hA5, 1'b0);
        repeat (3) tick();
        check("idle_count", 32'(COUNT), 0);
        check("idle_rd_valid", 32'(RD_VALID), 0);

        // Reset mid-word discards the partial byte
        start_pulse();
        send_byte(8'h55, 1'b0);
        reset_pulse();
        check("midword_rst_count", 32'(COUNT), 0);
        check("midword_rst_capturing", 32'(CAPTURING), 0);
        start_pulse();
        send_byte(8'h01, 1'b0);
        send_byte(8'h02, 1'b0);
        drain(6, "post_reset");

        // Partial-word timeout behaviour
        send_byte(8'h7F, 1'b0);
`ifdef UART_PACK_TIMEOUT_EN
        m_part.delete();
        exp_q.push_back(16'h007F);
        k = 0;
        while (COUNT == 0 && k <= 300) begin
            tick();
            k++;
        end
        check("timeout_cycle", k, TMO);
        check("timeout_count", 32'(COUNT), 1);
        drain(4, "timeout");
`else
        for (k = 0; k < 3 * TMO; k++) tick();
        check("no_timeout_count", 32'(COUNT), 0);
        check("no_timeout_valid", 32'(RD_VALID), 0);
`endif

        // Random traffic against the model with random consumer stalls
        stop_pulse();
        start_pulse();
        rand_rdy = 1'b1;
        for (int i = 0; i < 200; i++) begin
            if (i != 0 && (i % 64) == 0) begin
                stop_pulse();
                start_pulse();
            end
            send_byte(8'($urandom_range(0, 255)), 1'b0);
            check("rand_count", 32'(COUNT), exp_q.size());
            repeat ($urandom_range(0, 3)) tick();
        end
        check("rand_overflow", 32'(OVERFLOW), 32'(m_ovf));
        rand_rdy = 1'b0;
        drain(12, "rand");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule

// File: doc/uart_word_packer.md
UART_WORD_PACKER -- requirements
Module: uart_word_packer

Interface
REQ-001 Parameter BYTES_PER_WORD, default 2, SHALL set bytes packed per word (legal 1..4).
REQ-002 Parameter DEPTH, default 4096, SHALL set buffer depth in words (power of two, >=4).
REQ-003 Parameter TIMEOUT_CYC, default 52080, SHALL set idle cycles before partial-word flush (used only under REQ-033).
REQ-004 CLOCK_50  in  1  single clock; all logic on rising edge.
REQ-005 RST_N  in  1  reset, synchronous, active-low.
REQ-006 RX_DATA  in  8  received byte from UART receiver.
REQ-007 RX_BUSY  in  1  receiver busy; a byte is complete on its 1->0 transition.
REQ-008 START_N  in  1  active-low level; enables capture.
REQ-009 STOP_N  in  1  active-low level; disables capture and clears buffer.
REQ-010 RD_READY  in  1  consumer accepts RD_DATA.
REQ-011 RD_VALID  out  1  RD_DATA holds a valid word.
REQ-012 RD_DATA  out  8*BYTES_PER_WORD  packed word.
REQ-013 COUNT  out  $clog2(DEPTH)+1  words stored, including the output register.
REQ-014 OVERFLOW  out  1  sticky; a word was dropped.
REQ-015 CAPTURING  out  1  high in state RUN.

Function
REQ-016 States: IDLE, RUN; IDLE->RUN when START_N=0; RUN->IDLE when STOP_N=0; both low in the same cycle -> STOP wins.
REQ-017 RX_BUSY SHALL be registered once; byte strobe = registered & !current, one cycle.
REQ-018 In IDLE, byte strobes SHALL be ignored and the lane counter SHALL stay 0.
REQ-019 In RUN, byte k (0-based lane) SHALL be placed in RD_DATA bits [8k+7:8k] (little-endian; first byte is LSB).
REQ-020 The lane counter SHALL wrap from BYTES_PER_WORD-1 to 0; on wrap, the completed word SHALL be written at wr_ptr and wr_ptr SHALL advance.
REQ-021 Pointers SHALL wrap modulo DEPTH; full/empty SHALL be distinguished by COUNT, not pointer equality.
REQ-022 When the buffer is full, the completed word SHALL be discarded, pointers unchanged, and OVERFLOW set.
REQ-023 A pop in the same cycle as a write to a full buffer SHALL free the slot, so the write succeeds.
REQ-024 Reads: show-ahead; RD_VALID SHALL rise 2 cycles after the write of a word into an empty buffer (RAM read plus output register).
REQ-025 Pop SHALL occur on RD_VALID & RD_READY; the next word SHALL be presented the following cycle with no bubble while words remain.
REQ-026 RD_DATA SHALL hold stable while RD_VALID=1 and RD_READY=0.
REQ-027 Entering IDLE via STOP SHALL clear pointers, COUNT, the lane counter, the partial word and RD_VALID in that cycle.
REQ-028 OVERFLOW SHALL clear on the IDLE->RUN transition only.
REQ-029 Reading SHALL remain possible in RUN and in IDLE until the buffer is cleared.

Reset
REQ-030 With RST_N=0 at a clock edge: state IDLE, pointers 0, COUNT 0, RD_VALID 0, RD_DATA 0, OVERFLOW 0, CAPTURING 0, RX_BUSY register 1.
REQ-031 Reset mid-word or mid-read SHALL discard all buffered and partial data; RAM contents are don't-care.

Configuration
REQ-032 Macro UART_PACK_TIMEOUT_EN selects the timeout-flush feature.
REQ-033 Defined: in RUN with lane counter nonzero, TIMEOUT_CYC cycles without a byte strobe SHALL write the partial word zero-padded in the upper lanes and reset the lane counter; full-buffer rules apply.
REQ-034 Undefined: a partial word SHALL wait indefinitely; no timeout counter is synthesised.

Structure
REQ-035 Package uart_pkg SHALL hold the state enum type and the default BYTES_PER_WORD and DEPTH constants.
REQ-036 Storage SHALL be one sub-module, uart_dpram: simple dual-port RAM with registered read and one write port, parametrised by width and depth.

Verification
REQ-037 Bench: START_N pulse, bytes 0x34, 0x12 -> one word 0x1234; RD_VALID rises 2 cycles after the second strobe.
REQ-038 Bench: DEPTH=4, RD_READY=0, 10 bytes -> COUNT=4, OVERFLOW=1; the 5th word is dropped; a drain yields the first 4 words in order.
REQ-039 Bench: full buffer with pop in the same cycle as a 5th word write -> write accepted, COUNT stays 4, OVERFLOW stays 0.
REQ-040 Bench: STOP_N low after 3 bytes (1.5 words) -> COUNT=0, RD_VALID=0; after restart, 0xAA, 0xBB -> 0xBBAA, with no stale lane.
REQ-041 Bench: START_N and STOP_N low in the same cycle -> IDLE, CAPTURING=0; a byte strobe is ignored.
REQ-042 Bench: with UART_PACK_TIMEOUT_EN and TIMEOUT_CYC=100, byte 0x7F then idle -> word 0x007F written at cycle 100; without the macro -> no write.
